volume_ramp: RTL and testbench

Multi-channel, parametrised successor to the single-channel volume stage. It sits between the sample source and the DAC serialiser. Each channel gets its own gain, and the applied gain slews toward its target by a fixed step per sample frame, so volume changes and mute are click-free. Results are saturated and carried with a valid strobe through a fixed 2-cycle pipeline.

---
 rtl/volume_pkg.sv | 32 +++
 rtl/volume_ramp_if.sv | 40 ++++
 rtl/volume_ramp_ch.sv | 79 +++++++
 rtl/volume_ramp.sv | 108 ++++++++++
 tb/tb_volume_ramp.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/volume_pkg.sv
// Shared types and helpers for the multi-channel volume ramp.
// Holds the mute status FSM encoding and a generic signed saturation function.
package volume_pkg;

  typedef enum logic [1:0] {
    ST_UNMUTED  = 2'd0,
    ST_MUTING   = 2'd1,
    ST_MUTED    = 2'd2,
    ST_UNMUTING = 2'd3
  } mute_state_e;

  // Width of the intermediate used by sat_signed; product widths must fit in it.
  localparam int SAT_W = 64;

  // Clamp a wide signed value into the range of a signed 'width'-bit word.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/volume_ramp_if.sv
// Frame stream between sample source, volume ramp and DAC serialiser.
// master = the side that supplies frames and controls; slave = volume_ramp.
interface volume_ramp_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int VOL_W  = 8
) ();

  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] in_sample;
  logic [NUM_CH*VOL_W-1:0]  volume;
  logic                     mute;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_sample;
  logic                     ramping;
  logic                     muted;

  modport master (
    output in_valid,
    output in_sample,
    output volume,
    output mute,
    input  out_valid,
    input  out_sample,
    input  ramping,
    input  muted
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  volume,
    input  mute,
    output out_valid,
    output out_sample,
    output ramping,
    output muted
  );

endinterface

// File: rtl/volume_ramp_ch.sv
// One audio channel: slewing gain register plus a two-stage multiply / shift-saturate path.
// The valid pipeline lives in the parent; this block only needs its per-stage enables.
module volume_ramp_ch
  import volume_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int VOL_W     = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     stage1_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic [VOL_W-1:0]         target,
  output logic                     gain_zero,
  output logic                     at_target,
  output logic signed [DATA_W-1:0] out_sample
);

  localparam int              PROD_W = DATA_W + VOL_W + 1;
  localparam logic [VOL_W-1:0] STEP  = VOL_W'(RAMP_STEP);

  logic [VOL_W-1:0]         gain_q;
  logic [VOL_W-1:0]         gain_d;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [DATA_W-1:0] out_q;
  logic signed [DATA_W-1:0] out_d;
  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] shifted;

  // Slew toward the target; the step never overshoots, so no wrap is possible.
  always_comb begin
    gain_d = gain_q;
    if (in_valid) begin
      if (target >= gain_q) begin
        gain_d = (target - gain_q <= STEP) ? target : gain_q + STEP;
      end else begin
        gain_d = (gain_q - target <= STEP) ? target : gain_q - STEP;
      end
    end
  end

  assign gain_zero = (gain_d == '0);
  assign at_target = (gain_d == target);

  // Stage 1 scales by the gain held before this frame's update.
  always_comb begin
    sample_ext = PROD_W'(sample);
    gain_ext   = $signed(PROD_W'({1'b0, gain_q}));
    prod_d     = in_valid ? (sample_ext * gain_ext) : prod_q;
  end

  // Stage 2: arithmetic shift floors toward minus infinity, then clamp.
  always_comb begin
    shifted = prod_q >>> (VOL_W - 1);
    out_d   = out_q;
    if (stage1_valid) begin
      out_d = DATA_W'(sat_signed(SAT_W'(shifted), DATA_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q <= '0;
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      gain_q <= gain_d;
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign out_sample = out_q;

endmodule

// File: rtl/volume_ramp.sv
// Multi-channel click-free volume stage: per-channel slewing gains, saturated output,
// a global mute status FSM and the frame valid pipeline.
module volume_ramp
  import volume_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int VOL_W     = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic          clk,
  input  logic          reset,
  volume_ramp_if.slave  bus
);

  logic [NUM_CH-1:0]        gain_zero;
  logic [NUM_CH-1:0]        at_target;
  logic [NUM_CH*DATA_W-1:0] out_sample_w;
  logic                     all_zero;
  logic                     all_at_target;

  logic        stage1_valid_q;
  logic        stage1_valid_d;
  logic        out_valid_q;
  logic        out_valid_d;
  logic        ramping_q;
  logic        ramping_d;
  mute_state_e state_q;
  mute_state_e state_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [VOL_W-1:0] target;
      assign target = bus.mute ? '0 : bus.volume[gi*VOL_W +: VOL_W];

      volume_ramp_ch #(
        .DATA_W    (DATA_W),
        .VOL_W     (VOL_W),
        .RAMP_STEP (RAMP_STEP)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (bus.in_valid),
        .stage1_valid (stage1_valid_q),
        .sample       (bus.in_sample[gi*DATA_W +: DATA_W]),
        .target       (target),
        .gain_zero    (gain_zero[gi]),
        .at_target    (at_target[gi]),
        .out_sample   (out_sample_w[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Both reductions look at the gains as they will be after this edge.
  assign all_zero      = &gain_zero;
  assign all_at_target = &at_target;

  // Status FSM only; the gains themselves carry out the ramps.
  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        ST_UNMUTED: begin
          if (bus.mute) state_d = ST_MUTING;
        end
        ST_MUTING: begin
          if (!bus.mute)    state_d = ST_UNMUTING;
          else if (all_zero) state_d = ST_MUTED;
        end
        ST_MUTED: begin
          if (!bus.mute) state_d = ST_UNMUTING;
        end
        ST_UNMUTING: begin
          if (bus.mute)           state_d = ST_MUTING;
          else if (all_at_target) state_d = ST_UNMUTED;
        end
        default: state_d = ST_UNMUTED;
      endcase
    end
  end

  always_comb begin
    stage1_valid_d = bus.in_valid;
    out_valid_d    = stage1_valid_q;
    ramping_d      = bus.in_valid ? ~all_at_target : ramping_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_valid_q <= 1'b0;
      out_valid_q    <= 1'b0;
      ramping_q      <= 1'b0;
      state_q        <= ST_UNMUTED;
    end else begin
      stage1_valid_q <= stage1_valid_d;
      out_valid_q    <= out_valid_d;
      ramping_q      <= ramping_d;
      state_q        <= state_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_w;
  assign bus.ramping    = ramping_q;
  assign bus.muted      = (state_q == ST_MUTED);

endmodule

// File: tb/tb_volume_ramp.sv
// Directed bench for volume_ramp with default parameters (2 ch, 16-bit samples, 8-bit gain, step 4).
module tb_volume_ramp;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  volume_ramp_if #(.NUM_CH(2), .DATA_W(16), .VOL_W(8)) bus ();

  volume_ramp #(
    .NUM_CH    (2),
    .DATA_W    (16),
    .VOL_W     (8),
    .RAMP_STEP (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input int s0, input int s1,
                       input int vol0, input int vol1, input logic m);
    bus.in_valid  = v;
    bus.in_sample = {16'(s1), 16'(s0)};
    bus.volume    = {8'(vol1), 8'(vol0)};
    bus.mute      = m;
  endtask

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    $display("reset: ov=%0b out=%h ramping=%0b muted=%0b",
             bus.out_valid, bus.out_sample, bus.ramping, bus.muted);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_sample !== 32'h0) $display("FAIL reset_out_sample got %h expected 0", bus.out_sample);
    else n_pass++;
    n_checks++;
    if (bus.ramping !== 1'b0) $display("FAIL reset_ramping got %b expected 0", bus.ramping);
    else n_pass++;
    n_checks++;
    if (bus.muted !== 1'b0) $display("FAIL reset_muted got %b expected 0", bus.muted);
    else n_pass++;
  endtask

  // Gain 0 -> 128 in steps of 4: frame k scales 1000 by 4k/128 = 31.25k.
  task automatic test_ramp_up();
    int k, ex, g0, g1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1000, 1000, 128, 128, 1'b0);
      step();
      n_checks++;
      if (bus.ramping !== (i < 31)) $display("FAIL ramp_ramping frame %0d got %b expected %b", i, bus.ramping, (i < 31));
      else n_pass++;
      if (i >= 1) begin
        k  = i - 1;
        ex = (k < 32) ? (125 * k) / 4 : 1000;
        g0 = $signed(bus.out_sample[15:0]);
        g1 = $signed(bus.out_sample[31:16]);
        $display("ramp frame %0d: ov=%0b ch0=%0d ch1=%0d", k, bus.out_valid, g0, g1);
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL ramp_out_valid frame %0d got %b expected 1", k, bus.out_valid);
        else n_pass++;
        n_checks++;
        if (g0 != ex || g1 != ex) $display("FAIL ramp_out frame %0d got %0d/%0d expected %0d", k, g0, g1, ex);
        else n_pass++;
      end
    end
    drive(1'b0, 7, 7, 128, 128, 1'b0);
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL ramp_idle_valid got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_sample !== {16'd1000, 16'd1000}) $display("FAIL ramp_idle_hold got %h expected %h", bus.out_sample, {16'd1000, 16'd1000});
    else n_pass++;
  endtask

  // Gain 128 -> 0: frame j scales by (128-4j), i.e. 1000 - 31.25j floored.
  task automatic test_mute();
    int k, ex, g0;
    for (int j = 0; j < 36; j++) begin
      drive(1'b1, 1000, 1000, 128, 128, 1'b1);
      step();
      n_checks++;
      if (bus.muted !== (j >= 31)) $display("FAIL mute_muted frame %0d got %b expected %b", j, bus.muted, (j >= 31));
      else n_pass++;
      if (j >= 1) begin
        k  = j - 1;
        ex = (k >= 32) ? 0 : 1000 - (125 * k + 3) / 4;
        g0 = $signed(bus.out_sample[15:0]);
        $display("mute frame %0d: ch0=%0d muted=%0b", k, g0, bus.muted);
        n_checks++;
        if (g0 != ex || bus.out_sample[31:16] !== bus.out_sample[15:0])
          $display("FAIL mute_out frame %0d got %h expected %0d on both", k, bus.out_sample, ex);
        else n_pass++;
      end
    end
    drive(1'b0, 1000, 1000, 128, 128, 1'b1);
    step();
    step();
    n_checks++;
    if (bus.muted !== 1'b1 || bus.out_sample !== 32'h0)
      $display("FAIL mute_hold got muted=%b out=%h expected muted=1 out=0", bus.muted, bus.out_sample);
    else n_pass++;
    for (int u = 0; u < 32; u++) begin
      drive(1'b1, 1000, 1000, 128, 128, 1'b0);
      step();
      $display("unmute frame %0d: muted=%0b ramping=%0b", u, bus.muted, bus.ramping);
      n_checks++;
      if (bus.muted !== 1'b0 || bus.ramping !== (u < 31))
        $display("FAIL unmute frame %0d got muted=%b ramping=%b expected muted=0 ramping=%b", u, bus.muted, bus.ramping, (u < 31));
      else n_pass++;
    end
    drive(1'b0, 0, 0, 128, 128, 1'b0);
    step();
    step();
  endtask

  // Gain 128 -> 255 (31 steps of 4, then 3), then clamp and floor cases.
  task automatic test_saturation();
    int g0, g1;
    int sa0[3] = '{30000, -1, 100};
    int sa1[3] = '{-30000, -1, -100};
    int ex0[3] = '{32767, -2, 199};
    int ex1[3] = '{-32768, -2, -200};
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 0, 0, 255, 255, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, sa0[i], sa1[i], 255, 255, 1'b0);
      else       drive(1'b0, 0, 0, 255, 255, 1'b0);
      step();
      if (i >= 1) begin
        g0 = $signed(bus.out_sample[15:0]);
        g1 = $signed(bus.out_sample[31:16]);
        $display("sat frame %0d: ch0=%0d ch1=%0d", i - 1, g0, g1);
        n_checks++;
        if (g0 != ex0[i-1] || g1 != ex1[i-1])
          $display("FAIL sat_out frame %0d got %0d/%0d expected %0d/%0d", i - 1, g0, g1, ex0[i-1], ex1[i-1]);
        else n_pass++;
      end
    end
    step();
    g0 = $signed(bus.out_sample[15:0]);
    n_checks++;
    if (bus.out_valid !== 1'b0 || g0 != 199)
      $display("FAIL sat_hold got ov=%b ch0=%0d expected ov=0 ch0=199", bus.out_valid, g0);
    else n_pass++;
  endtask

  // From reset: ch0 -> 64 (16 frames), ch1 -> 200 (50 frames); 4000 * 4k/128 = 125k.
  task automatic test_channels();
    int k, e0, e1, g0, g1;
    do_reset();
    for (int i = 0; i < 55; i++) begin
      drive(1'b1, 4000, 4000, 64, 200, 1'b0);
      step();
      n_checks++;
      if (bus.ramping !== (i < 49)) $display("FAIL chan_ramping frame %0d got %b expected %b", i, bus.ramping, (i < 49));
      else n_pass++;
      if (i >= 1) begin
        k  = i - 1;
        e0 = 125 * ((k < 16) ? k : 16);
        e1 = 125 * ((k < 50) ? k : 50);
        g0 = $signed(bus.out_sample[15:0]);
        g1 = $signed(bus.out_sample[31:16]);
        $display("chan frame %0d: ch0=%0d ch1=%0d", k, g0, g1);
        n_checks++;
        if (g0 != e0 || g1 != e1) $display("FAIL chan_out frame %0d got %0d/%0d expected %0d/%0d", k, g0, g1, e0, e1);
        else n_pass++;
      end
    end
    drive(1'b0, 0, 0, 64, 200, 1'b0);
    step();
    step();
  endtask

  // Sample 128 makes out_sample equal to the gain used for that frame.
  task automatic test_retarget();
    int k, ex, g0;
    do_reset();
    for (int n = 0; n < 18; n++) begin
      drive(1'b1, 128, 128, (n < 10) ? 128 : 20, (n < 10) ? 128 : 20, 1'b0);
      step();
      if (n >= 1) begin
        k  = n - 1;
        ex = (k < 10) ? 4 * k : ((40 - 4 * (k - 10) > 20) ? 40 - 4 * (k - 10) : 20);
        g0 = $signed(bus.out_sample[15:0]);
        $display("retarget frame %0d: gain=%0d", k, g0);
        n_checks++;
        if (g0 != ex || bus.out_sample[31:16] !== bus.out_sample[15:0])
          $display("FAIL retarget frame %0d got %h expected %0d on both", k, bus.out_sample, ex);
        else n_pass++;
      end
    end
  endtask

  // Continues from gain 20 with frame 17 still in flight; gaps must freeze gain and output.
  task automatic test_back_to_back_gaps_and_reset();
    int g0;
    int v_pat[13]  = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0};
    int ex_ov[13]  = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0};
    int ex_out[13] = '{20, 20, 20, 20, 24, 24, 28, 32, 32, 32, 32, 36, 36};
    for (int s = 0; s < 13; s++) begin
      drive(v_pat[s] != 0, 128, 128, 100, 100, 1'b0);
      step();
      g0 = $signed(bus.out_sample[15:0]);
      $display("gap cycle %0d: in_valid=%0d ov=%0b out=%0d", s, v_pat[s], bus.out_valid, g0);
      n_checks++;
      if (bus.out_valid !== 1'(ex_ov[s]) || g0 != ex_out[s])
        $display("FAIL gap cycle %0d got ov=%b out=%0d expected ov=%0d out=%0d", s, bus.out_valid, g0, ex_ov[s], ex_out[s]);
      else n_pass++;
    end
    drive(1'b1, 128, 128, 100, 100, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sample !== 32'h0)
      $display("FAIL midreset_first got ov=%b out=%h expected ov=0 out=0", bus.out_valid, bus.out_sample);
    else n_pass++;
    drive(1'b0, 128, 128, 100, 100, 1'b0);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL midreset_second got ov=%b expected 0", bus.out_valid);
    else n_pass++;
    drive(1'b1, 128, 128, 100, 100, 1'b0);
    step();
    step();
    g0 = $signed(bus.out_sample[15:0]);
    $display("post-reset frame 0: ov=%0b gain=%0d", bus.out_valid, g0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || g0 != 0) $display("FAIL postreset_gain0 got ov=%b out=%0d expected ov=1 out=0", bus.out_valid, g0);
    else n_pass++;
    drive(1'b0, 0, 0, 100, 100, 1'b0);
    step();
    g0 = $signed(bus.out_sample[15:0]);
    $display("post-reset frame 1: ov=%0b gain=%0d", bus.out_valid, g0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || g0 != 4) $display("FAIL postreset_gain4 got ov=%b out=%0d expected ov=1 out=4", bus.out_valid, g0);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    test_reset();
    test_ramp_up();
    test_mute();
    test_saturation();
    test_channels();
    test_retarget();
    test_back_to_back_gaps_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
